// File: rtl/mem_access_unit_pkg.sv
// Shared types and codes for the memory access sequencer.
// State encoding and error codes are visible to the top module and to external monitors.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MAU_IDLE = 2'b00,
    MAU_BUSY = 2'b01,
    MAU_DONE = 2'b10,
    MAU_ERR  = 2'b11
  } mau_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Cycle counter for the BUSY phase.
// It clears while idle, counts while enabled, and saturates once it reaches TIMEOUT-1.
module mau_timeout_counter #(
  parameter int TIMEOUT = 16
) (
  input  logic cclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && !expired) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expired = (cnt_reg == LAST);

endmodule

// File: rtl/mem_access_unit.sv
// Bus sequencer between the multicycle control unit and a variable-latency memory.
// Runs one req/ack transaction per memory state and stalls the core while that transaction is in flight.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              cclk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              IrWrite,
  input  logic              IorD,
  input  logic [DATA_W-1:0] Pc,
  input  logic [DATA_W-1:0] AluOut,
  input  logic [DATA_W-1:0] BReg,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              Stall,
  output logic [DATA_W-1:0] Ir,
  output logic [DATA_W-1:0] Mdr,
  output logic              MemErr,
  output logic [1:0]        ErrCode
);

  mau_state_t        state_reg, state_next;
  logic [DATA_W-1:0] addr_sel;
  logic              cmd, issue, align_err, timeout_err, rd_done, expired;
  logic              mem_we_reg, ir_write_reg, mem_err_reg;
  logic [DATA_W-1:0] mem_addr_reg, mem_wdata_reg, ir_reg, mdr_reg;
  logic [1:0]        err_code_reg;

  assign cmd      = MemRead | MemWrite;
  assign addr_sel = IorD ? AluOut : Pc;

  mau_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .cclk    (cclk),
    .rst     (rst),
    .clear   (state_reg != MAU_BUSY),
    .enable  (state_reg == MAU_BUSY),
    .expired (expired)
  );

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) state_reg <= MAU_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    Stall       = 1'b0;
    issue       = 1'b0;
    align_err   = 1'b0;
    timeout_err = 1'b0;
    rd_done     = 1'b0;
    case (state_reg)
      MAU_IDLE: begin
        if (cmd) begin
          Stall = 1'b1;
          if (!is_word_aligned(addr_sel[1:0])) begin
            align_err  = 1'b1;
            state_next = MAU_ERR;
          end else begin
            issue      = 1'b1;
            state_next = MAU_BUSY;
          end
        end
      end
      MAU_BUSY: begin
        Stall = 1'b1;
        // An ack in the final counted cycle still completes the access.
        if (mem_ack) begin
          rd_done    = !mem_we_reg;
          state_next = MAU_DONE;
        end else if (expired) begin
          timeout_err = 1'b1;
          state_next  = MAU_ERR;
        end
      end
      MAU_DONE: state_next = MAU_IDLE;
      MAU_ERR:  Stall = 1'b1;
      default:  state_next = MAU_IDLE;
    endcase
  end

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mem_we_reg    <= 1'b0;
      ir_write_reg  <= 1'b0;
      ir_reg        <= '0;
      mdr_reg       <= '0;
      mem_err_reg   <= 1'b0;
      err_code_reg  <= ERR_NONE;
    end else begin
      if (issue) begin
        mem_addr_reg  <= addr_sel;
        mem_wdata_reg <= BReg;
        mem_we_reg    <= MemWrite;
        // When write wins over read, the fetch qualifier is dropped with the read.
        ir_write_reg  <= IrWrite & ~MemWrite;
      end
      if (rd_done) begin
        mdr_reg <= mem_rdata;
        if (ir_write_reg) ir_reg <= mem_rdata;
      end
      if (align_err) begin
        mem_err_reg  <= 1'b1;
        err_code_reg <= ERR_ALIGN;
      end else if (timeout_err) begin
        mem_err_reg  <= 1'b1;
        err_code_reg <= ERR_TIMEOUT;
      end
    end
  end

  assign mem_req   = (state_reg == MAU_BUSY);
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign Ir        = ir_reg;
  assign Mdr       = mdr_reg;
  assign MemErr    = mem_err_reg;
  assign ErrCode   = err_code_reg;

endmodule
